// File: rtl/qpu_lsu_ctrl_if.sv
// ICB command/response bundle shared by the AGU, mres and memory sides
// of the LSU controller.
//
// Handshake: a beat transfers on a rising clk edge where valid and ready
// are both 1. Once valid is raised, the initiator keeps valid and every
// payload field stable until that beat transfers. ready may depend
// combinationally on valid; valid never depends on ready.
interface qpu_lsu_ctrl_if #(
    parameter int AW     = 32,
    parameter int XLEN   = 32,
    parameter int ITAG_W = 5
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AW-1:0]     cmd_addr;
    logic              cmd_read;
    logic [XLEN-1:0]   cmd_wdata;
    logic [XLEN/8-1:0] cmd_wmask;
    logic [ITAG_W-1:0] cmd_itag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic [ITAG_W-1:0] rsp_itag;

    // Issues commands, consumes responses.
    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_itag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_itag
    );

    // Accepts commands, produces responses.
    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_itag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_itag
    );
endinterface

// File: rtl/qpu_lsu_ctrl.sv
// qpu_lsu_ctrl: arbitrates the AGU and mres command paths onto one memory
// ICB port and routes in-order memory responses back to the issuer using
// an outstanding FIFO of {src, itag}. src 0 = AGU, 1 = mres.
module qpu_lsu_ctrl #(
    parameter int XLEN       = 32,
    parameter int AW         = 32,
    parameter int ITAG_W     = 5,
    parameter int OUTS_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    qpu_lsu_ctrl_if.slave               agu_icb,
    qpu_lsu_ctrl_if.slave               mres_icb,
    qpu_lsu_ctrl_if.master              mem_icb,
    output logic                        lsu_busy,
    output logic [$clog2(OUTS_DEPTH):0] lsu_outs_cnt
);
    localparam int PW = $clog2(OUTS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(OUTS_DEPTH);

    logic [PW-1:0]                   wptr_q, wptr_d;
    logic [PW-1:0]                   rptr_q, rptr_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic                            lock_q, lock_d;
    logic                            lock_src_q, lock_src_d;
    logic                            last_grant_q, last_grant_d;
    logic [OUTS_DEPTH-1:0]             fifo_src_q, fifo_src_d;
    logic [OUTS_DEPTH-1:0][ITAG_W-1:0] fifo_itag_q, fifo_itag_d;

    logic              full;
    logic              empty;
    logic              grant;
    logic              cmd_hs;
    logic              rsp_hs;
    logic              head_src;
    logic [ITAG_W-1:0] head_itag;

    // Arbitration and command mux; a held (locked) grant keeps the mem cmd stable.
    always_comb begin
        full  = (cnt_q == DEPTH);
        empty = (cnt_q == '0);
        if (lock_q) begin
            grant = lock_src_q;
        end else if (agu_icb.cmd_valid && mres_icb.cmd_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = mres_icb.cmd_valid;
        end
        // Full blocks issue outright; a same-cycle pop does not bypass it.
        mem_icb.cmd_valid  = ~full & (grant ? mres_icb.cmd_valid : agu_icb.cmd_valid);
        mem_icb.cmd_addr   = grant ? mres_icb.cmd_addr  : agu_icb.cmd_addr;
        mem_icb.cmd_read   = grant ? mres_icb.cmd_read  : agu_icb.cmd_read;
        mem_icb.cmd_wdata  = grant ? mres_icb.cmd_wdata : agu_icb.cmd_wdata;
        mem_icb.cmd_wmask  = grant ? mres_icb.cmd_wmask : agu_icb.cmd_wmask;
        mem_icb.cmd_itag   = grant ? mres_icb.cmd_itag  : agu_icb.cmd_itag;
        agu_icb.cmd_ready  = ~grant & mem_icb.cmd_ready & ~full;
        mres_icb.cmd_ready =  grant & mem_icb.cmd_ready & ~full;
        cmd_hs             = mem_icb.cmd_valid & mem_icb.cmd_ready;
    end

    // Response routing from the FIFO head; an empty FIFO blocks stray responses.
    always_comb begin
        head_src           = fifo_src_q[rptr_q];
        head_itag          = fifo_itag_q[rptr_q];
        mem_icb.rsp_ready  = ~empty & (head_src ? mres_icb.rsp_ready : agu_icb.rsp_ready);
        agu_icb.rsp_valid  = mem_icb.rsp_valid & ~empty & ~head_src;
        mres_icb.rsp_valid = mem_icb.rsp_valid & ~empty &  head_src;
        agu_icb.rsp_rdata  = mem_icb.rsp_rdata;
        mres_icb.rsp_rdata = mem_icb.rsp_rdata;
        agu_icb.rsp_err    = mem_icb.rsp_err;
        mres_icb.rsp_err   = mem_icb.rsp_err;
        agu_icb.rsp_itag   = head_itag;
        mres_icb.rsp_itag  = head_itag;
        rsp_hs             = mem_icb.rsp_valid & mem_icb.rsp_ready;
        lsu_busy           = ~empty;
        lsu_outs_cnt       = cnt_q;
    end

    // Next-state: FIFO push/pop, occupancy, grant lock and round-robin pointer.
    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        fifo_src_d   = fifo_src_q;
        fifo_itag_d  = fifo_itag_q;
        last_grant_d = last_grant_q;
        if (cmd_hs) begin
            fifo_src_d[wptr_q]  = grant;
            fifo_itag_d[wptr_q] = grant ? mres_icb.cmd_itag : agu_icb.cmd_itag;
            wptr_d              = wptr_q + PW'(1);
            last_grant_d        = grant;
        end
        if (rsp_hs) begin
            rptr_d = rptr_q + PW'(1);
        end
        cnt_d      = cnt_q + CW'(cmd_hs) - CW'(rsp_hs);
        // Lock while a presented command is stalled by memory.
        lock_d     = mem_icb.cmd_valid & ~mem_icb.cmd_ready;
        lock_src_d = grant;
    end

    // State registers; reset drops all outstanding entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            lock_q       <= 1'b0;
            lock_src_q   <= 1'b0;
            last_grant_q <= 1'b1;
            fifo_src_q   <= '0;
            fifo_itag_q  <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            lock_q       <= lock_d;
            lock_src_q   <= lock_src_d;
            last_grant_q <= last_grant_d;
            fifo_src_q   <= fifo_src_d;
            fifo_itag_q  <= fifo_itag_d;
        end
    end
endmodule

// File: tb/tb_qpu_lsu_ctrl.sv
// tb_qpu_lsu_ctrl: directed scenarios plus a random phase. A memory model
// answers in order; a scoreboard queue holds the expected response for
// every accepted requester command.
module tb_qpu_lsu_ctrl;
    localparam int XLEN   = 32;
    localparam int AW     = 32;
    localparam int ITAG_W = 5;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int EW     = 1 + ITAG_W + 1 + XLEN;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lsu_busy;
    logic [CW-1:0] lsu_outs_cnt;

    qpu_lsu_ctrl_if #(.AW(AW), .XLEN(XLEN), .ITAG_W(ITAG_W)) agu_if ();
    qpu_lsu_ctrl_if #(.AW(AW), .XLEN(XLEN), .ITAG_W(ITAG_W)) mres_if ();
    qpu_lsu_ctrl_if #(.AW(AW), .XLEN(XLEN), .ITAG_W(ITAG_W)) mem_if ();

    qpu_lsu_ctrl #(.XLEN(XLEN), .AW(AW), .ITAG_W(ITAG_W), .OUTS_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .agu_icb      (agu_if),
        .mres_icb     (mres_if),
        .mem_icb      (mem_if),
        .lsu_busy     (lsu_busy),
        .lsu_outs_cnt (lsu_outs_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int            checks = 0;
    int            errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [AW-1:0] pend_q[$];
    int            hs_cnt = 0;
    int            pop_count = 0;

    bit rsp_en    = 1'b1;
    int rsp_delay = 0;
    bit spur_en   = 1'b0;
    int wait_cnt  = 0;
    int seen_pops = 0;

    function automatic logic [XLEN-1:0] rdata_f(input logic [AW-1:0] a);
        return a ^ 32'hDEADBFEF;
    endfunction

    function automatic logic err_f(input logic [AW-1:0] a);
        return a[4];
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: compares every delivered response with the queue head and
    // records accepted commands (responses are retired before new pushes).
    logic          a_hs, m_hs, mc_hs, mr_hs, a_rhs, m_rhs;
    logic [EW-1:0] m_exp, m_got;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pend_q.delete();
        end else begin
            a_hs  = agu_if.cmd_valid & agu_if.cmd_ready;
            m_hs  = mres_if.cmd_valid & mres_if.cmd_ready;
            mc_hs = mem_if.cmd_valid & mem_if.cmd_ready;
            mr_hs = mem_if.rsp_valid & mem_if.rsp_ready;
            a_rhs = agu_if.rsp_valid & agu_if.rsp_ready;
            m_rhs = mres_if.rsp_valid & mres_if.rsp_ready;
            if (agu_if.rsp_valid || mres_if.rsp_valid)
                chk("rsp_onehot", agu_if.rsp_valid & mres_if.rsp_valid, 0);
            if (a_rhs || m_rhs) begin
                chk("mem_rsp_hs", mr_hs, 1);
                m_got = a_rhs ? {1'b0, agu_if.rsp_itag, agu_if.rsp_err, agu_if.rsp_rdata}
                              : {1'b1, mres_if.rsp_itag, mres_if.rsp_err, mres_if.rsp_rdata};
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    m_exp = exp_q.pop_front();
                    chk("rsp_src_itag_err_data", m_got, m_exp);
                end
            end
            if (mr_hs) begin
                if (pend_q.size() != 0) void'(pend_q.pop_front());
                pop_count++;
            end
            if (a_hs || m_hs) chk("mem_cmd_hs", mc_hs, 1);
            if (a_hs) begin
                chk("agu_mux_addr", mem_if.cmd_addr, agu_if.cmd_addr);
                chk("agu_mux_wr", {mem_if.cmd_read, mem_if.cmd_wmask, mem_if.cmd_wdata},
                    {agu_if.cmd_read, agu_if.cmd_wmask, agu_if.cmd_wdata});
                exp_q.push_back({1'b0, agu_if.cmd_itag, err_f(agu_if.cmd_addr), rdata_f(agu_if.cmd_addr)});
            end
            if (m_hs) begin
                chk("mres_mux_addr", mem_if.cmd_addr, mres_if.cmd_addr);
                chk("mres_mux_wr", {mem_if.cmd_read, mem_if.cmd_wmask, mem_if.cmd_wdata},
                    {mres_if.cmd_read, mres_if.cmd_wmask, mres_if.cmd_wdata});
                exp_q.push_back({1'b1, mres_if.cmd_itag, err_f(mres_if.cmd_addr), rdata_f(mres_if.cmd_addr)});
            end
            if (mc_hs) begin
                pend_q.push_back(mem_if.cmd_addr);
                hs_cnt++;
            end
        end
    end

    // Memory model: in-order responses after rsp_delay idle cycles each.
    always @(posedge clk) begin
        #1;
        if (pop_count != seen_pops) begin
            seen_pops = pop_count;
            wait_cnt  = 0;
        end
        if (rst) begin
            mem_if.rsp_valid = 1'b0;
            wait_cnt         = 0;
        end else if (spur_en) begin
            mem_if.rsp_valid = 1'b1;
            mem_if.rsp_rdata = '0;
            mem_if.rsp_err   = 1'b0;
        end else if (rsp_en && pend_q.size() != 0) begin
            if (wait_cnt >= rsp_delay) begin
                mem_if.rsp_valid = 1'b1;
                mem_if.rsp_rdata = rdata_f(pend_q[0]);
                mem_if.rsp_err   = err_f(pend_q[0]);
            end else begin
                mem_if.rsp_valid = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_if.rsp_valid = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input bit src, input logic [AW-1:0] a, input logic rd, input logic [ITAG_W-1:0] t);
        if (src) begin
            mres_if.cmd_valid = 1'b1; mres_if.cmd_addr = a; mres_if.cmd_read = rd;
            mres_if.cmd_wdata = $urandom; mres_if.cmd_wmask = 4'($urandom_range(0, 15)); mres_if.cmd_itag = t;
        end else begin
            agu_if.cmd_valid = 1'b1; agu_if.cmd_addr = a; agu_if.cmd_read = rd;
            agu_if.cmd_wdata = $urandom; agu_if.cmd_wmask = 4'($urandom_range(0, 15)); agu_if.cmd_itag = t;
        end
    endtask

    task automatic idle_cmd(input bit src);
        if (src) mres_if.cmd_valid = 1'b0;
        else     agu_if.cmd_valid  = 1'b0;
    endtask

    task automatic issue(input bit src, input logic [AW-1:0] a, input logic rd, input logic [ITAG_W-1:0] t);
        bit hs = 1'b0;
        int n  = 0;
        tick();
        drive_cmd(src, a, rd, t);
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = src ? (mres_if.cmd_valid & mres_if.cmd_ready) : (agu_if.cmd_valid & agu_if.cmd_ready);
            n++;
        end
        if (!hs) chk("issue_timeout", 0, 1);
        tick();
        idle_cmd(src);
    endtask

    task automatic reset_dut();
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk); #1;
        while (n < budget && !(exp_q.size() == 0 && lsu_outs_cnt == 0)) begin
            @(negedge clk); #1;
            n++;
        end
        chk("idle_reached", n < budget, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit a, m;
        int n, guard, h0;
        logic [XLEN-1:0] wd;

        agu_if.cmd_valid = 0; agu_if.cmd_addr = 0; agu_if.cmd_read = 0; agu_if.cmd_wdata = 0;
        agu_if.cmd_wmask = 0; agu_if.cmd_itag = 0; agu_if.rsp_ready = 0;
        mres_if.cmd_valid = 0; mres_if.cmd_addr = 0; mres_if.cmd_read = 0; mres_if.cmd_wdata = 0;
        mres_if.cmd_wmask = 0; mres_if.cmd_itag = 0; mres_if.rsp_ready = 0;
        mem_if.cmd_ready = 0; mem_if.rsp_itag = 0;

        // Reset state with nothing active.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {agu_if.cmd_ready, mres_if.cmd_ready, mem_if.cmd_valid}, 0);
        chk("rst_rsp", {mem_if.rsp_ready, agu_if.rsp_valid, mres_if.rsp_valid}, 0);
        chk("rst_busy_cnt", {lsu_busy, lsu_outs_cnt}, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        mem_if.cmd_ready = 1; agu_if.rsp_ready = 1; mres_if.rsp_ready = 1;

        // Stray memory response with an empty FIFO is blocked.
        spur_en = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("spur_rsp_ready", mem_if.rsp_ready, 0);
        chk("spur_rsp_valid", {agu_if.rsp_valid, mres_if.rsp_valid}, 0);
        spur_en = 1'b0;

        // AGU-only load with a two-cycle memory response.
        rsp_delay = 1;
        tick();
        drive_cmd(0, 32'h100, 1'b1, 5'd3);
        @(negedge clk);
        chk("t1_mem_valid", mem_if.cmd_valid, 1);
        chk("t1_cnt0", lsu_outs_cnt, 0);
        tick();
        idle_cmd(0);
        @(negedge clk);
        chk("t1_cnt1", {lsu_busy, lsu_outs_cnt}, {1'b1, 3'd1});
        chk("t1_no_early_rsp", agu_if.rsp_valid, 0);
        n = 0;
        while (!agu_if.rsp_valid && n < 10) begin @(negedge clk); n++; end
        chk("t1_rsp_valid", agu_if.rsp_valid, 1);
        chk("t1_rdata", agu_if.rsp_rdata, 32'hDEADBEEF);
        chk("t1_itag", agu_if.rsp_itag, 3);
        chk("t1_mres_quiet", mres_if.rsp_valid, 0);
        @(negedge clk);
        chk("t1_cnt_back0", {lsu_busy, lsu_outs_cnt}, 0);
        rsp_delay = 0;

        // Tie arbitration after reset: AGU, mres, AGU, mres.
        reset_dut();
        tick();
        drive_cmd(0, 32'($urandom), 1'b1, 5'd0);
        drive_cmd(1, 32'($urandom), 1'b0, 5'd16);
        n = 0; guard = 0;
        while (n < 4 && guard < 40) begin
            @(negedge clk);
            a = agu_if.cmd_valid & agu_if.cmd_ready;
            m = mres_if.cmd_valid & mres_if.cmd_ready;
            if (a || m) begin
                chk("tie_grant", {a, m}, (n % 2 == 0) ? 2'b10 : 2'b01);
                n++;
            end
            guard++;
            tick();
            if (a) drive_cmd(0, 32'($urandom), 1'b1, 5'(n));
            if (m) drive_cmd(1, 32'($urandom), 1'b0, 5'(16 + n));
        end
        chk("tie_count", n, 4);
        idle_cmd(0); idle_cmd(1);
        wait_idle(40);

        // Grant lock: mres stalls first, AGU joins; mem cmd must not move.
        reset_dut();
        tick();
        mem_if.cmd_ready = 0;
        drive_cmd(1, 32'h500, 1'b0, 5'd9);
        wd = mres_if.cmd_wdata;
        @(negedge clk);
        chk("lock_c0", {mem_if.cmd_valid, mem_if.cmd_addr, mem_if.cmd_read, mem_if.cmd_wdata},
            {1'b1, 32'h500, 1'b0, wd});
        tick();
        drive_cmd(0, 32'h600, 1'b1, 5'd4);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("lock_hold", {mem_if.cmd_valid, mem_if.cmd_addr, mem_if.cmd_read, mem_if.cmd_wdata},
                {1'b1, 32'h500, 1'b0, wd});
            chk("lock_readys", {agu_if.cmd_ready, mres_if.cmd_ready}, 0);
        end
        tick();
        mem_if.cmd_ready = 1;
        h0 = hs_cnt;
        @(negedge clk);
        chk("lock_release", {mem_if.cmd_addr, agu_if.cmd_ready, mres_if.cmd_ready}, {32'h500, 2'b01});
        tick();
        chk("lock_single_hs", hs_cnt, h0 + 1);
        idle_cmd(1);
        @(negedge clk);
        chk("lock_next_agu", {agu_if.cmd_ready, mres_if.cmd_ready}, 2'b10);
        tick();
        idle_cmd(0);
        wait_idle(40);

        // Full: four outstanding, fifth blocked; a pop frees it next cycle.
        reset_dut();
        rsp_en = 0;
        for (int i = 0; i < 4; i++) issue(0, 32'h1000 + 32'(i * 4), 1'b1, 5'(i));
        tick();
        drive_cmd(0, 32'h2000, 1'b1, 5'd20);
        @(negedge clk);
        chk("full_cnt", {lsu_busy, lsu_outs_cnt}, {1'b1, 3'd4});
        chk("full_block", {agu_if.cmd_ready, mres_if.cmd_ready, mem_if.cmd_valid}, 0);
        rsp_en = 1;
        @(negedge clk);
        chk("full_pop", mem_if.rsp_ready, 1);
        chk("full_no_bypass", {agu_if.cmd_ready, mem_if.cmd_valid}, 0);
        @(negedge clk);
        chk("full_release", {agu_if.cmd_ready, mem_if.cmd_valid, lsu_outs_cnt}, {2'b11, 3'd3});
        tick();
        idle_cmd(0);
        wait_idle(40);

        // Interleaved routing with a held first response.
        reset_dut();
        rsp_en = 0;
        issue(0, 32'h210, 1'b1, 5'd1);
        issue(1, 32'h304, 1'b0, 5'd7);
        issue(0, 32'h418, 1'b1, 5'd2);
        tick();
        agu_if.rsp_ready = 0;
        @(negedge clk);
        chk("il_cnt3", lsu_outs_cnt, 3);
        rsp_en = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("il_hold_ready", mem_if.rsp_ready, 0);
            chk("il_hold_route", {agu_if.rsp_valid, mres_if.rsp_valid, agu_if.rsp_itag}, {2'b10, 5'd1});
        end
        tick();
        agu_if.rsp_ready = 1;
        wait_idle(40);

        // Reset with three outstanding.
        rsp_en = 0;
        issue(0, 32'h700, 1'b1, 5'd11);
        issue(1, 32'h710, 1'b0, 5'd12);
        issue(0, 32'h720, 1'b1, 5'd13);
        @(negedge clk);
        chk("mf_cnt3", lsu_outs_cnt, 3);
        reset_dut();
        rsp_en = 1;
        @(negedge clk);
        chk("mf_after_rst", {lsu_busy, lsu_outs_cnt, mem_if.rsp_ready}, 0);
        tick();
        drive_cmd(0, 32'h730, 1'b1, 5'd14);
        drive_cmd(1, 32'h740, 1'b0, 5'd15);
        @(negedge clk);
        chk("mf_tie_agu", {agu_if.cmd_ready, mres_if.cmd_ready}, 2'b10);
        tick();
        idle_cmd(0); idle_cmd(1);
        wait_idle(40);

        // Random traffic with back-pressure on every side.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            a = agu_if.cmd_valid & agu_if.cmd_ready;
            m = mres_if.cmd_valid & mres_if.cmd_ready;
            if ($urandom_range(0, 15) == 0) rsp_delay = $urandom_range(0, 2);
            tick();
            if (!agu_if.cmd_valid || a) begin
                if ($urandom_range(0, 1) == 1) drive_cmd(0, 32'($urandom), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
                else idle_cmd(0);
            end
            if (!mres_if.cmd_valid || m) begin
                if ($urandom_range(0, 1) == 1) drive_cmd(1, 32'($urandom), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
                else idle_cmd(1);
            end
            agu_if.rsp_ready  = ($urandom_range(0, 3) != 0);
            mres_if.rsp_ready = ($urandom_range(0, 3) != 0);
            mem_if.cmd_ready  = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        rsp_delay = 0;
        tick();
        idle_cmd(0); idle_cmd(1);
        agu_if.rsp_ready = 1; mres_if.rsp_ready = 1; mem_if.cmd_ready = 1;
        wait_idle(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
